// File: rtl/dynamixel_write_scheduler_pkg.sv
// Shared types, widths and flattened-bus slice helpers for the Dynamixel write scheduler.
package dynamixel_sched_pkg;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 16;
    localparam int LEN_W   = 16;
    localparam int VAL_W   = 32;
    localparam int NUM_VAL = 4;
    localparam int IDX_W   = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_START,
        ST_WAIT_DONE,
        ST_GAP
    } state_e;

    function automatic int addr_lo(input int idx);
        return idx * ADDR_W;
    endfunction

    function automatic int len_lo(input int idx);
        return idx * LEN_W;
    endfunction

    // Requester idx owns NUM_VAL consecutive words; word 0 is value1.
    function automatic int val_lo(input int idx, input int word);
        return idx * NUM_VAL * VAL_W + word * VAL_W;
    endfunction

    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/dynamixel_write_scheduler_if.sv
// Requester/engine bundle of the write scheduler; master = scheduler, slave = requesters + engine.
interface dynamixel_write_scheduler_if;
    import dynamixel_sched_pkg::*;

    logic [NUM_REQ-1:0]               req;
    logic [NUM_REQ*ADDR_W-1:0]        req_address;
    logic [NUM_REQ*LEN_W-1:0]         req_data_len;
    logic [NUM_REQ*NUM_VAL*VAL_W-1:0] req_values;
    logic [NUM_REQ-1:0]               gnt;
    logic                             busy;
    logic                             timeout;
    logic                             send;
    logic [ADDR_W-1:0]                address;
    logic [LEN_W-1:0]                 data_len;
    logic [VAL_W-1:0]                 value1;
    logic [VAL_W-1:0]                 value2;
    logic [VAL_W-1:0]                 value3;
    logic [VAL_W-1:0]                 value4;
    logic                             sending;

    modport master (
        input  req, req_address, req_data_len, req_values, sending,
        output gnt, busy, timeout, send, address, data_len,
               value1, value2, value3, value4
    );

    modport slave (
        output req, req_address, req_data_len, req_values, sending,
        input  gnt, busy, timeout, send, address, data_len,
               value1, value2, value3, value4
    );

endinterface

// File: rtl/dynamixel_write_scheduler_rr_arbiter4.sv
// Combinational 4-way round-robin arbiter; DYNAMIXEL_SCHED_PRIORITY_EN gives requester 0
// strict priority and freezes the pointer when it wins.
module rr_arbiter4
    import dynamixel_sched_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               valid_o,
    output logic               adv_ptr_o
);

    logic [IDX_W-1:0] cand;

    // NOTE: every output gets a default before any branch so no latch is inferred.
    always_comb begin
        grant_o   = '0;
        idx_o     = '0;
        adv_ptr_o = 1'b1;
        cand      = '0;
        valid_o   = |req_i;
        // Scan farthest offset first so the nearest requester at/after ptr overwrites it.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = ptr_i + IDX_W'(k);
            if (req_i[cand]) begin
                idx_o = cand;
            end
        end
        if (valid_o) begin
            grant_o = NUM_REQ'(1) << idx_o;
        end
`ifdef DYNAMIXEL_SCHED_PRIORITY_EN
        if (req_i[0]) begin
            idx_o     = '0;
            grant_o   = NUM_REQ'(1);
            adv_ptr_o = 1'b0;
        end
`endif
    end

endmodule

// File: rtl/dynamixel_write_scheduler.sv
// Shares one sync-write engine among four requesters: arbitrate, latch payload, pulse send,
// track sending, enforce a bus gap. Optional DYNAMIXEL_SCHED_PRIORITY_EN: requester 0 strict priority.
module dynamixel_write_scheduler
    import dynamixel_sched_pkg::*;
#(
    parameter int START_TIMEOUT = 64,
    parameter int GAP_CLOCKS    = 120
) (
    input logic                         clock,
    input logic                         reset_n,
    dynamixel_write_scheduler_if.master bus
);

    localparam int               CNT_W        = cnt_width(START_TIMEOUT, GAP_CLOCKS);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(START_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'((GAP_CLOCKS > 0) ? GAP_CLOCKS - 1 : 0);

    state_e             state_q;
    logic [IDX_W-1:0]   ptr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_sat;
    logic [NUM_REQ-1:0] gnt_q;
    logic               send_q;
    logic               timeout_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [LEN_W-1:0]   len_q;
    logic [VAL_W-1:0]   val_q [NUM_VAL];

    logic [NUM_REQ-1:0] arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_valid;
    logic               arb_adv;

    logic [ADDR_W-1:0]  addr_d;
    logic [LEN_W-1:0]   len_d;
    logic [VAL_W-1:0]   val_d [NUM_VAL];

    rr_arbiter4 u_arb (
        .req_i     (bus.req),
        .ptr_i     (ptr_q),
        .grant_o   (arb_grant),
        .idx_o     (arb_idx),
        .valid_o   (arb_valid),
        .adv_ptr_o (arb_adv)
    );

    // Winner's payload slice, selected from the flattened request buses.
    always_comb begin
        addr_d = '0;
        len_d  = '0;
        for (int w = 0; w < NUM_VAL; w++) val_d[w] = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_idx == IDX_W'(i)) begin
                addr_d = bus.req_address[addr_lo(i) +: ADDR_W];
                len_d  = bus.req_data_len[len_lo(i) +: LEN_W];
                for (int w = 0; w < NUM_VAL; w++) begin
                    val_d[w] = bus.req_values[val_lo(i, w) +: VAL_W];
                end
            end
        end
    end

    assign cnt_sat = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            gnt_q     <= '0;
            send_q    <= 1'b0;
            timeout_q <= 1'b0;
            // NOTE: payload registers are reset as well so the engine never sees X after reset.
            addr_q    <= '0;
            len_q     <= '0;
            for (int w = 0; w < NUM_VAL; w++) val_q[w] <= '0;
        end else begin
            gnt_q     <= '0;
            send_q    <= 1'b0;
            timeout_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (arb_valid) begin
                        addr_q <= addr_d;
                        len_q  <= len_d;
                        for (int w = 0; w < NUM_VAL; w++) val_q[w] <= val_d[w];
                        send_q <= 1'b1;
                        gnt_q  <= arb_grant;
                        if (arb_adv) ptr_q <= arb_idx + 1'b1;
                        cnt_q   <= '0;
                        state_q <= ST_WAIT_START;
                    end
                end
                ST_WAIT_START: begin
                    // A rising sending beats an expiring timeout in the same cycle.
                    if (bus.sending) begin
                        state_q <= ST_WAIT_DONE;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        timeout_q <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= ST_GAP;
                    end else begin
                        cnt_q <= cnt_sat;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!bus.sending) begin
                        cnt_q   <= '0;
                        state_q <= (GAP_CLOCKS == 0) ? ST_IDLE : ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (GAP_CLOCKS == 0 || cnt_q == GAP_LAST) begin
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_sat;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.send     = send_q;
    assign bus.timeout  = timeout_q;
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.address  = addr_q;
    assign bus.data_len = len_q;
    assign bus.value1   = val_q[0];
    assign bus.value2   = val_q[1];
    assign bus.value3   = val_q[2];
    assign bus.value4   = val_q[3];

endmodule

// File: doc/dynamixel_write_scheduler.md
# dynamixel_write_scheduler

Shares the single Dynamixel sync-write packet engine between four requesters (e.g. torque enable, goal position, LED, diagnostics). It arbitrates round-robin, latches the winner's payload, pulses the engine's `send`, and tracks the engine's `sending` flag to completion. It also enforces a programmable inter-packet bus gap. It sits between the top-level control logic and the sync-write engine, which remains the only driver of the half-duplex bus.

## Interface
- `START_TIMEOUT`, default 64: clocks allowed between `send` and `sending` rising before abort.
- `GAP_CLOCKS`, default 120: idle clocks enforced after `sending` falls (10 µs at 12 MHz); 0 is legal.
- `clock` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `req` in 4: per-requester request level; bit i = requester i.
- `req_address` in 64: 4×16 control-table addresses; requester i at [16i+15:16i].
- `req_data_len` in 64: 4×16 data lengths, same packing.
- `req_values` in 512: 4×(4×32) servo values; requester i at [128i+127:128i], value1 in low 32 bits.
- `gnt` out 4: one-cycle grant pulse; payload was captured in that cycle.
- `busy` out 1: high in every state except IDLE.
- `timeout` out 1: one-cycle pulse on start timeout.
- `send` out 1: one-cycle start pulse to the engine.
- `address` out 16, `data_len` out 16, `value1`..`value4` out 32 each: registered payload to the engine, held until the next grant.
- `sending` in 1: engine busy flag.

## Operation
- FSM states are IDLE, WAIT_START, WAIT_DONE and GAP.
- IDLE:
  - With any `req` bit high, pick the winner by round-robin from pointer `ptr`.
  - Register the winner's payload onto the outputs. Assert `send` and `gnt[winner]` for one cycle.
  - Set `ptr` to (winner+1) mod 4 and go to WAIT_START.
- WAIT_START:
  - `sending`=1 → WAIT_DONE.
  - Otherwise count; at `START_TIMEOUT` cycles, pulse `timeout` and go to GAP.
- WAIT_DONE: `sending`=0 → GAP, or IDLE directly when `GAP_CLOCKS`=0.
- GAP: count `GAP_CLOCKS` cycles, then go to IDLE.
- Requester rules:
  - Hold `req` and payload stable until `gnt[i]` is seen.
  - Drop `req` in the cycle after `gnt` unless another packet is wanted.
  - A `req` still high after GAP is a new request.
- Requests arriving while `busy` are ignored until IDLE. No queueing beyond one pending level per requester.
- Counter width is $clog2 of max(`START_TIMEOUT`, `GAP_CLOCKS`)+1. The count saturates and never wraps.
- `sending` is ignored in IDLE and GAP. This tolerates a late `sending` falling edge.

## Timing
- Reset values:
  - All outputs 0; `address`, `data_len` and values also 0.
  - `ptr`=0, state IDLE, counter 0.
- Async assert; reset_n deasserts cleanly into IDLE.
- Latency: `req` high at edge k gives `send`, `gnt` and payload valid after edge k. `send` is exactly one cycle wide.
- Earliest next `send` after `sending` falls is `GAP_CLOCKS`+1 cycles.
- Simultaneous requests: the lowest index at or after `ptr` wins.
- `sending` rising in the same cycle the timeout expires: rising wins (WAIT_DONE, no `timeout`).
- Reset mid-packet: the FSM returns to IDLE. The engine may still finish, and its `sending` is ignored until the next grant.

## Configuration
- Macro: `DYNAMIXEL_SCHED_PRIORITY_EN`.
- Defined: requester 0 has strict priority over round-robin. Whenever `req[0]` is high in IDLE it wins, and `ptr` is not updated. This is intended for emergency torque-off.
- Undefined: pure 4-way round-robin across all requesters.

## Structure
- Package `dynamixel_sched_pkg`:
  - state enum.
  - `NUM_REQ`=4, `ADDR_W`=16, `LEN_W`=16, `VAL_W`=32.
  - slice-index helper functions for the flattened buses.
- Sub-module `rr_arbiter4`: `req`+`ptr` in, one-hot winner and index out. Purely combinational; the priority macro is applied inside it.

## Test plan
- Single request: `req`=0001, address 64, len 1, values 1/1/1/1; stub engine raises `sending` 2 cycles after `send` and holds it 50 cycles → one `send`, `gnt`=0001, outputs 64/1/1…; next `send` is impossible for 121 cycles after `sending` falls.
- Round-robin: `req`=1111 held → grants 0001, 0010, 0100, 1000, 0001 in order; each payload matches its slice.
- Start timeout: stub never raises `sending` → `timeout` pulses exactly 64 cycles after `send`, then GAP, then a re-grant of the next requester.
- `GAP_CLOCKS`=0 build: `sending` falls → `busy` low the next cycle; pending `req` is granted the cycle after.
- Priority build (macro defined): `req`=1111 continuously → requester 0 granted every packet; macro undefined → rotation as in the round-robin test.
- Reset mid-WAIT_DONE: `reset_n` low for 3 cycles → all outputs 0, `busy` 0 asynchronously; stale `sending`=1 ignored; the next `req`=0100 is granted immediately.
